// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-select codes, tnew/tuse
// constants, the pipeline-entry record and the bubble value loaded on stall/reset.
package hazard_pkg;

  // Operand source selects
  localparam logic [1:0] FwdRf = 2'b00;  // register file
  localparam logic [1:0] FwdW  = 2'b01;  // W-stage result
  localparam logic [1:0] FwdM  = 2'b10;  // M-stage result
  localparam logic [1:0] FwdE  = 2'b11;  // E-stage result (D selects only)

  // Cycles after entering E until the result exists
  localparam logic [1:0] TnewJal = 2'd0;
  localparam logic [1:0] TnewAlu = 2'd1;
  localparam logic [1:0] TnewLw  = 2'd2;

  // Cycles from D until the operand is consumed
  localparam logic [1:0] TuseBranch = 2'd0;
  localparam logic [1:0] TuseAlu    = 2'd1;
  localparam logic [1:0] TuseStore  = 2'd2;

  // Producer half of an entry: everything the comparators need
  typedef struct packed {
    logic       regwr;
    logic [4:0] a3;
    logic [1:0] tnew;
  } prod_t;

  typedef struct packed {
    prod_t      prod;
    logic [4:0] rs;
    logic [4:0] rt;
  } entry_t;

  // All-zero entry: writes nothing, reads nothing
  localparam entry_t BubbleEntry = '0;

  // An entry produces reg_num if it writes it; register 0 is never produced
  function automatic logic producer_match(prod_t p, logic [4:0] reg_num);
    return p.regwr && (p.a3 == reg_num) && (reg_num != 5'd0);
  endfunction

  // tnew one stage later: max(t - 1, 0)
  function automatic logic [1:0] age_tnew(logic [1:0] t);
    case (t)
      2'd3:    return TnewLw;
      TnewLw:  return TnewAlu;
      default: return TnewJal;
    endcase
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Per-operand hazard comparator. Checks one source register against the E, M
// and W producers and returns a stall request plus a forward select.
//   reg_num  - operand register number
//   use_op   - operand is actually read (D operands)
//   tuse     - cycles until the operand is needed, measured from D
//   is_e_op  - 1: operand belongs to the instruction in E (only M/W considered,
//              never stalls); 0: operand belongs to the instruction in D
//   prod_e/m/w - producer fields of the three pipeline entries
//   stall    - operand cannot be satisfied this cycle
//   sel      - forward select (FwdRf/FwdW/FwdM/FwdE)
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] reg_num,
  input  logic       use_op,
  input  logic [1:0] tuse,
  input  logic       is_e_op,
  input  prod_t      prod_e,
  input  prod_t      prod_m,
  input  prod_t      prod_w,
  output logic       stall,
  output logic [1:0] sel
);

  logic hit_e, hit_m, hit_w;

  always_comb begin
    stall = 1'b0;
    sel   = FwdRf;
    hit_e = producer_match(prod_e, reg_num) && !is_e_op;
    hit_m = producer_match(prod_m, reg_num);
    hit_w = producer_match(prod_w, reg_num);

    if (is_e_op) begin
      // E operand is consumed now: M only qualifies once its result exists
      if (hit_m && (prod_m.tnew == TnewJal)) begin
        sel = FwdM;
      end else if (hit_w) begin
        sel = FwdW;
      end
    end else if (use_op) begin
      // Youngest producer decides, even if an older one is already ready
      if (hit_e) begin
        if (prod_e.tnew > tuse) stall = 1'b1;
        else                    sel   = FwdE;
      end else if (hit_m) begin
        if (prod_m.tnew > tuse) stall = 1'b1;
        else                    sel   = FwdM;
      end else if (hit_w) begin
        if (prod_w.tnew > tuse) stall = 1'b1;
        else                    sel   = FwdW;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard. Tracks the instructions in E, M and W, stalls the
// D-stage instruction when a needed operand cannot be produced in time, and
// generates forward selects for the D and E operands.
//   clk, rst_n            - clock, asynchronous active-low reset
//   rs_D/rt_D, use_*_D,
//   tuse_*_D              - D-stage source operands and when they are needed
//   regwr_D, a3_D, tnew_D - D-stage destination and when its result appears
//   stall                 - freeze PC and F/D, bubble into E
//   fwd_rs_D/fwd_rt_D     - D operand selects
//   fwd_rs_E/fwd_rt_E     - E operand selects
//   stall_cnt             - saturating count of stall cycles since reset
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        regwr_D,
  input  logic [4:0]  a3_D,
  input  logic [1:0]  tnew_D,
  output logic        stall,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic [15:0] stall_cnt
);

  entry_t e_q, e_d;
  entry_t m_q, m_d;
  entry_t w_q, w_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic stall_rs_d, stall_rt_d;
  logic unused_stall_rs_e, unused_stall_rt_e;
  logic unused_w_src;

  // W source fields are tracked for completeness but nothing downstream reads them
  assign unused_w_src = ^{w_q.rs, w_q.rt};

  hazard_cmp u_cmp_rs_d (
    .reg_num (rs_D),
    .use_op  (use_rs_D),
    .tuse    (tuse_rs_D),
    .is_e_op (1'b0),
    .prod_e  (e_q.prod),
    .prod_m  (m_q.prod),
    .prod_w  (w_q.prod),
    .stall   (stall_rs_d),
    .sel     (fwd_rs_D)
  );

  hazard_cmp u_cmp_rt_d (
    .reg_num (rt_D),
    .use_op  (use_rt_D),
    .tuse    (tuse_rt_D),
    .is_e_op (1'b0),
    .prod_e  (e_q.prod),
    .prod_m  (m_q.prod),
    .prod_w  (w_q.prod),
    .stall   (stall_rt_d),
    .sel     (fwd_rt_D)
  );

  hazard_cmp u_cmp_rs_e (
    .reg_num (e_q.rs),
    .use_op  (1'b1),
    .tuse    (TuseBranch),
    .is_e_op (1'b1),
    .prod_e  (e_q.prod),
    .prod_m  (m_q.prod),
    .prod_w  (w_q.prod),
    .stall   (unused_stall_rs_e),
    .sel     (fwd_rs_E)
  );

  hazard_cmp u_cmp_rt_e (
    .reg_num (e_q.rt),
    .use_op  (1'b1),
    .tuse    (TuseBranch),
    .is_e_op (1'b1),
    .prod_e  (e_q.prod),
    .prod_m  (m_q.prod),
    .prod_w  (w_q.prod),
    .stall   (unused_stall_rt_e),
    .sel     (fwd_rt_E)
  );

  assign stall     = stall_rs_d | stall_rt_d;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    e_d = BubbleEntry;
    if (!stall) begin
      e_d.prod.regwr = regwr_D;
      e_d.prod.a3    = a3_D;
      e_d.prod.tnew  = tnew_D;
      e_d.rs         = rs_D;
      e_d.rt         = rt_D;
    end

    m_d           = e_q;
    m_d.prod.tnew = age_tnew(e_q.prod.tnew);

    w_d           = m_q;
    w_d.prod.tnew = TnewJal;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= BubbleEntry;
      m_q         <= BubbleEntry;
      w_q         <= BubbleEntry;
      stall_cnt_q <= 16'd0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
